// File: rtl/angelia_i2s_slave_rx_if.sv
// Pin and result bundle for the I2S slave receiver.
// The master side drives BCLK/LRCLK/DIN; the slave side (the receiver) returns the words and status.
interface angelia_i2s_slave_rx_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  BCLK_IN;
  logic                  LRCLK_IN;
  logic                  DIN;
  logic [DATA_WIDTH-1:0] l_data;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  data_valid;
  logic                  locked;
  logic                  frame_err;

  modport master (
    output BCLK_IN, LRCLK_IN, DIN,
    input  l_data, r_data, data_valid, locked, frame_err
  );

  modport slave (
    input  BCLK_IN, LRCLK_IN, DIN,
    output l_data, r_data, data_valid, locked, frame_err
  );
endinterface

// File: rtl/angelia_i2s_slave_rx.sv
// I2S slave receiver: synchronises BCLK/LRCLK/DIN, deserialises stereo words and checks frame timing.
// Define I2S_RX_LJ_EN for left-justified framing (MSB on the LRCLK-change bit, LRCLK 1 = left).
module angelia_i2s_slave_rx #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned SLOT_BITS    = 32,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned BCLK_TIMEOUT = 255
) (
  input logic                   CLK_IN,
  input logic                   reset_n,
  angelia_i2s_slave_rx_if.slave bus
);
  localparam int unsigned K_W    = $clog2(SLOT_BITS) + 1;
  localparam int unsigned IDLE_W = $clog2(BCLK_TIMEOUT + 1);
  localparam logic [K_W-1:0]    K_MAX    = '1;
  localparam logic [IDLE_W-1:0] IDLE_MAX = '1;

  logic [SYNC_STAGES-1:0] bclk_sync, lr_sync, din_sync;
  logic                   bclk_hist;
  logic [K_W-1:0]         k;
  logic                   lr_prev, lr_valid, first, pend;
  logic [1:0]             good_cnt;
  logic [IDLE_W-1:0]      idle_cnt;
  logic [DATA_WIDTH-1:0]  shifter, l_hold, r_hold;

  logic                  rise_det, lr_s, din_s, lr_chg, len_ok, shift_en, word_done, is_left;
  logic [K_W-1:0]        k_cur;
  logic [DATA_WIDTH-1:0] shift_next;

  // Bit position of the current rise and the data-slot decode for the selected format.
  always_comb begin
    rise_det   = bclk_sync[SYNC_STAGES-1] & ~bclk_hist;
    lr_s       = lr_sync[SYNC_STAGES-1];
    din_s      = din_sync[SYNC_STAGES-1];
    lr_chg     = lr_valid & (lr_s != lr_prev);
    k_cur      = lr_chg ? '0 : ((k == K_MAX) ? K_MAX : k + K_W'(1));
    len_ok     = ((K_W+1)'(k) + (K_W+1)'(1)) == (K_W+1)'(SLOT_BITS);
    shift_next = {shifter[DATA_WIDTH-2:0], din_s};
`ifdef I2S_RX_LJ_EN
    is_left    = lr_s;
    shift_en   = (first | lr_chg) & (k_cur <= K_W'(DATA_WIDTH - 1));
    word_done  = shift_en & (k_cur == K_W'(DATA_WIDTH - 1));
`else
    is_left    = ~lr_s;
    shift_en   = (first | lr_chg) & (k_cur >= K_W'(1)) & (k_cur <= K_W'(DATA_WIDTH));
    word_done  = shift_en & (k_cur == K_W'(DATA_WIDTH));
`endif
  end

  always_ff @(posedge CLK_IN or negedge reset_n) begin
    if (!reset_n) begin
      bclk_sync      <= '0;
      lr_sync        <= '0;
      din_sync       <= '0;
      bclk_hist      <= 1'b0;
      k              <= '0;
      lr_prev        <= 1'b0;
      lr_valid       <= 1'b0;
      first          <= 1'b0;
      pend           <= 1'b0;
      good_cnt       <= '0;
      idle_cnt       <= '0;
      shifter        <= '0;
      l_hold         <= '0;
      r_hold         <= '0;
      bus.l_data     <= '0;
      bus.r_data     <= '0;
      bus.data_valid <= 1'b0;
      bus.locked     <= 1'b0;
      bus.frame_err  <= 1'b0;
    end else begin
      bclk_sync      <= {bclk_sync[SYNC_STAGES-2:0], bus.BCLK_IN};
      lr_sync        <= {lr_sync[SYNC_STAGES-2:0], bus.LRCLK_IN};
      din_sync       <= {din_sync[SYNC_STAGES-2:0], bus.DIN};
      bclk_hist      <= bclk_sync[SYNC_STAGES-1];
      bus.data_valid <= 1'b0;
      bus.frame_err  <= 1'b0;
      pend           <= 1'b0;

      // Publish the pair one cycle after the right word lands in its hold.
      if (pend) begin
        bus.l_data     <= l_hold;
        bus.r_data     <= r_hold;
        bus.data_valid <= 1'b1;
      end

      if (rise_det) begin
        idle_cnt <= '0;
        lr_prev  <= lr_s;
        if (!lr_valid) begin
          lr_valid <= 1'b1;
          k        <= '0;
        end else begin
          k <= k_cur;
          if (lr_chg) begin
            first <= 1'b1;
            if (first) begin
              if (len_ok) begin
                if (good_cnt != 2'd2) good_cnt <= good_cnt + 2'd1;
                if (good_cnt != 2'd0) bus.locked <= 1'b1;
              end else begin
                bus.frame_err <= 1'b1;
                good_cnt      <= '0;
                bus.locked    <= 1'b0;
              end
            end
          end
          if (shift_en) begin
            shifter <= shift_next;
            if (word_done) begin
              if (is_left) begin
                l_hold <= shift_next;
              end else begin
                r_hold <= shift_next;
                pend   <= bus.locked;
              end
            end
          end
        end
      end else begin
        if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + IDLE_W'(1);
        // BCLK has gone quiet: forget framing so the next burst starts from scratch.
        if (idle_cnt == IDLE_W'(BCLK_TIMEOUT - 1)) begin
          bus.locked <= 1'b0;
          good_cnt   <= '0;
          first      <= 1'b0;
          lr_valid   <= 1'b0;
          k          <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_angelia_i2s_slave_rx.sv
// Bench for angelia_i2s_slave_rx: half-frame level reference model predicts pairs, errors and lock.
`timescale 1ns/1ps
module tb_angelia_i2s_slave_rx;
  localparam int unsigned DW    = 16;
  localparam int unsigned SLOT  = 32;
  localparam real         CLK_P = 8.138;
`ifdef I2S_RX_LJ_EN
  localparam bit          LJ    = 1'b1;
  localparam int unsigned NEED  = DW;
  localparam logic [15:0] BASE_L = 16'h1234;
  localparam logic [15:0] BASE_R = 16'hFEDC;
`else
  localparam bit          LJ    = 1'b0;
  localparam int unsigned NEED  = DW + 1;
  localparam logic [15:0] BASE_L = 16'hA5C3;
  localparam logic [15:0] BASE_R = 16'h5A3C;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  angelia_i2s_slave_rx_if #(.DATA_WIDTH(DW)) bus ();

  angelia_i2s_slave_rx dut (.CLK_IN(clk), .reset_n(rst_n), .bus(bus));

  always #(CLK_P / 2.0) clk = ~clk;

  int checks = 0;
  int failures = 0;
  int fe_cnt = 0;
  int exp_fe = 0;
  bit exp_locked = 1'b0;
  logic [15:0] m_lhold = '0;
  logic [31:0] exp_q[$];
  realtime last_rise_t = 0.0;

  // One queued half-frame: channel, BCLK rises, word, filler style for unused slots.
  bit          h_left[$];
  int          h_n[$];
  logic [15:0] h_w[$];
  bit          h_fill1[$];

  // Every published pair is checked against the model's next expected pair.
  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) fe_cnt++;
    if (bus.data_valid === 1'b1) begin
      logic [31:0] e;
      checks++;
      if (bus.locked !== 1'b1) begin
        failures++;
        $display("FAIL dv_while_unlocked locked=%b required=1", bus.locked);
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL dv_unexpected got=%h_%h required=none", bus.l_data, bus.r_data);
      end else begin
        e = exp_q.pop_front();
        if ({bus.l_data, bus.r_data} !== e)
          begin failures++; $display("FAIL dv_pair got=%h_%h required=%h_%h", bus.l_data, bus.r_data, e[31:16], e[15:0]); end
      end
    end
  end

  task automatic add_half(input bit left, input int n, input logic [15:0] w, input bit fill1);
    h_left.push_back(left); h_n.push_back(n); h_w.push_back(w); h_fill1.push_back(fill1);
  endtask

  // Standard alternating stream: partial first half, then full halves with the given words.
  task automatic add_stream(input bit start_left, input int first_len, input int halves, input bit rnd);
    bit left;
    left = start_left;
    add_half(left, first_len, 16'($urandom), 1'b0);
    for (int i = 0; i < halves; i++) begin
      left = ~left;
      add_half(left, SLOT, rnd ? 16'($urandom) : (left ? BASE_L : BASE_R), 1'b0);
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    bus.BCLK_IN = 1'b0; bus.LRCLK_IN = 1'b0; bus.DIN = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    exp_q.delete(); fe_cnt = 0; exp_fe = 0; exp_locked = 1'b0; m_lhold = '0;
    repeat (4) @(posedge clk);
  endtask

  // Predict the stream from half-frame rules, then drive it on the pins.
  task automatic run_seq();
    int good;
    bit lk;
    good = 0; lk = 1'b0;
    for (int i = 0; i < h_n.size(); i++) begin
      if (i >= 2) begin
        if (h_n[i-1] == SLOT) begin
          if (good < 2) good++;
          if (good == 2) lk = 1'b1;
        end else begin
          exp_fe++; good = 0; lk = 1'b0;
        end
      end
      if (i >= 1 && h_n[i] >= NEED) begin
        if (h_left[i]) m_lhold = h_w[i];
        else if (lk) exp_q.push_back({m_lhold, h_w[i]});
      end
    end
    exp_locked = lk;
    for (int i = 0; i < h_n.size(); i++) begin
      logic [15:0] w;
      w = h_w[i];
      for (int j = 0; j < h_n[i]; j++) begin
        bit b;
        b = h_fill1[i] ? 1'b1 : 1'($urandom);
        if (!LJ && j >= 1 && j <= DW) b = w[DW-j];
        if (LJ && j < DW) b = w[DW-1-j];
        bus.BCLK_IN = 1'b0;
        bus.LRCLK_IN = LJ ? h_left[i] : ~h_left[i];
        bus.DIN = b;
        #80;
        bus.BCLK_IN = 1'b1;
        last_rise_t = $realtime;
        #80;
      end
    end
    bus.BCLK_IN = 1'b0;
    h_left.delete(); h_n.delete(); h_w.delete(); h_fill1.delete();
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_dut();
    @(negedge clk);
    checks++; if (bus.l_data !== 16'h0) begin failures++; $display("FAIL rst_l_data got=%h required=0000", bus.l_data); end
    checks++; if (bus.r_data !== 16'h0) begin failures++; $display("FAIL rst_r_data got=%h required=0000", bus.r_data); end
    checks++; if (bus.data_valid !== 1'b0) begin failures++; $display("FAIL rst_data_valid got=%b required=0", bus.data_valid); end
    checks++; if (bus.locked !== 1'b0) begin failures++; $display("FAIL rst_locked got=%b required=0", bus.locked); end
    checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL rst_frame_err got=%b required=0", bus.frame_err); end
  endtask

  task automatic test_basic();
    reset_dut();
    add_stream(1'b1, 20, 8, 1'b0);
    run_seq();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL basic_dv_count missing=%0d required=0", exp_q.size()); end
    checks++; if (fe_cnt != exp_fe) begin failures++; $display("FAIL basic_frame_err got=%0d required=%0d", fe_cnt, exp_fe); end
    checks++; if (bus.locked !== exp_locked) begin failures++; $display("FAIL basic_locked got=%b required=%b", bus.locked, exp_locked); end
  endtask

  task automatic test_random();
    reset_dut();
    add_stream(1'($urandom), 1 + int'($urandom_range(30)), 10, 1'b1);
    run_seq();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rand_dv_count missing=%0d required=0", exp_q.size()); end
    checks++; if (fe_cnt != exp_fe) begin failures++; $display("FAIL rand_frame_err got=%0d required=%0d", fe_cnt, exp_fe); end
    checks++; if (bus.locked !== exp_locked) begin failures++; $display("FAIL rand_locked got=%b required=%b", bus.locked, exp_locked); end
  endtask

  task automatic test_frame_err();
    reset_dut();
    add_stream(1'b1, 9, 13, 1'b1);
    h_n[5] = SLOT - 1;
    h_n[10] = SLOT + 1;
    run_seq();
    checks++; if (fe_cnt != exp_fe) begin failures++; $display("FAIL ferr_count got=%0d required=%0d", fe_cnt, exp_fe); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL ferr_dv_count missing=%0d required=0", exp_q.size()); end
    checks++; if (bus.locked !== exp_locked) begin failures++; $display("FAIL ferr_locked got=%b required=%b", bus.locked, exp_locked); end
  endtask

  task automatic test_timeout();
    logic [15:0] l_before;
    int fe_before, cyc;
    bit fell;
    reset_dut();
    add_stream(1'b1, 12, 5, 1'b1);
    add_half(1'b1, 10, 16'($urandom), 1'b0);
    run_seq();
    checks++; if (bus.locked !== exp_locked) begin failures++; $display("FAIL to_locked_before got=%b required=%b", bus.locked, exp_locked); end
    l_before = bus.l_data;
    fe_before = fe_cnt;
    fell = 1'b0;
    for (int c = 0; c < 600 && !fell; c++) begin
      @(negedge clk);
      if (bus.locked !== 1'b1) fell = 1'b1;
    end
    cyc = int'(($realtime - last_rise_t) / CLK_P);
    checks++;
    if (!fell || cyc < 256 || cyc > 261) begin
      failures++; $display("FAIL to_lock_drop fell=%b cycles=%0d required=256..261", fell, cyc);
    end
    repeat (150) @(negedge clk);
    checks++; if (fe_cnt != fe_before) begin failures++; $display("FAIL to_no_frame_err got=%0d required=%0d", fe_cnt, fe_before); end
    checks++; if (bus.l_data !== l_before) begin failures++; $display("FAIL to_hold_l_data got=%h required=%h", bus.l_data, l_before); end
    add_stream(1'b0, 7, 8, 1'b1);
    run_seq();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL to_dv_count missing=%0d required=0", exp_q.size()); end
    checks++; if (bus.locked !== exp_locked) begin failures++; $display("FAIL to_relock got=%b required=%b", bus.locked, exp_locked); end
  endtask

  task automatic test_async_reset();
    reset_dut();
    add_stream(1'b1, 9, 5, 1'b1);
    add_half(1'b1, 8, 16'($urandom), 1'b0);
    run_seq();
    checks++; if (bus.locked !== exp_locked) begin failures++; $display("FAIL ar_locked_before got=%b required=%b", bus.locked, exp_locked); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL ar_dv_before missing=%0d required=0", exp_q.size()); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (bus.l_data !== 16'h0) begin failures++; $display("FAIL ar_l_data got=%h required=0000", bus.l_data); end
    checks++; if (bus.r_data !== 16'h0) begin failures++; $display("FAIL ar_r_data got=%h required=0000", bus.r_data); end
    checks++; if (bus.locked !== 1'b0) begin failures++; $display("FAIL ar_locked got=%b required=0", bus.locked); end
    reset_dut();
    add_stream(1'b1, 6, 8, 1'b1);
    run_seq();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL ar_dv_after missing=%0d required=0", exp_q.size()); end
    checks++; if (bus.locked !== exp_locked) begin failures++; $display("FAIL ar_relock got=%b required=%b", bus.locked, exp_locked); end
  endtask

  task automatic test_bit_order();
    reset_dut();
    add_half(1'b1, 5, 16'h0000, 1'b1);
    add_half(1'b0, SLOT, 16'h7FFF, 1'b1);
    add_half(1'b1, SLOT, 16'h8000, 1'b1);
    add_half(1'b0, SLOT, 16'h7FFF, 1'b1);
    add_half(1'b1, SLOT, 16'hFFFF, 1'b1);
    add_half(1'b0, SLOT, 16'h0001, 1'b1);
    add_half(1'b1, 4, 16'h0000, 1'b1);
    run_seq();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL bits_dv_count missing=%0d required=0", exp_q.size()); end
    checks++; if (bus.r_data !== 16'h0001) begin failures++; $display("FAIL bits_last_r got=%h required=0001", bus.r_data); end
    checks++; if (bus.l_data !== 16'hFFFF) begin failures++; $display("FAIL bits_last_l got=%h required=ffff", bus.l_data); end
  endtask

  initial begin
    bus.BCLK_IN = 1'b0; bus.LRCLK_IN = 1'b0; bus.DIN = 1'b0;
    test_reset();
    test_basic();
    test_random();
    test_frame_err();
    test_timeout();
    test_async_reset();
    test_bit_order();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
